// File: rtl/usb_tx_phy.sv
// Full-speed USB transmit PHY: SYNC, LSB-first data with bit stuffing and NRZI, then EOP.
// Bytes arrive from the SIE on a tx_data/tx_valid/tx_ready handshake; line outputs are registered.
module usb_tx_phy #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       d_p,
    output logic       d_n,
    output logic       d_oe
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SYNC    = 3'd1,
        ST_DATA    = 3'd2,
        ST_EOP_SE0 = 3'd3,
        ST_EOP_J   = 3'd4
    } state_t;

    state_t           state_r;
    logic [DIV_W-1:0] div_r;
    logic [2:0]       bit_idx_r;
    logic [2:0]       ones_r;
    logic [7:0]       shreg_r;
    logic             tx_ready_r;
    logic             d_p_r;
    logic             d_n_r;
    logic             d_oe_r;

    logic             strobe_s;
    logic [2:0]       next_idx_s;
    logic             emit_en_s;
    logic             emit_val_s;
    logic             load_s;
    logic             eop_s;
    logic             adv_s;

    assign strobe_s   = (div_r == DIV_W'(CLK_DIV - 1));
    assign next_idx_s = bit_idx_r + 3'd1;

    // Decide what the next bit period carries at each bit strobe of SYNC/DATA.
    // A stuffed bit is just an emitted 0 that does not advance the bit index.
    always_comb begin
        emit_en_s  = 1'b0;
        emit_val_s = 1'b0;
        load_s     = 1'b0;
        eop_s      = 1'b0;
        adv_s      = 1'b0;
        if (strobe_s && ((state_r == ST_SYNC) || (state_r == ST_DATA))) begin
            if ((state_r == ST_DATA) && (ones_r == 3'd6)) begin
                emit_en_s  = 1'b1;
                emit_val_s = 1'b0;
            end else if (bit_idx_r == 3'd7) begin
                if (tx_valid) begin
                    load_s     = 1'b1;
                    emit_en_s  = 1'b1;
                    emit_val_s = tx_data[0];
                end else begin
                    eop_s = 1'b1;
                end
            end else begin
                adv_s      = 1'b1;
                emit_en_s  = 1'b1;
                emit_val_s = (state_r == ST_SYNC) ? (next_idx_s == 3'd7) : shreg_r[next_idx_s];
            end
        end else begin
            emit_en_s = 1'b0;
        end
    end

    // Packet sequencer, bit-period divider, NRZI line driver and handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            div_r      <= '0;
            bit_idx_r  <= 3'd0;
            ones_r     <= 3'd0;
            shreg_r    <= 8'h00;
            tx_ready_r <= 1'b0;
            d_p_r      <= 1'b1;
            d_n_r      <= 1'b0;
            d_oe_r     <= 1'b0;
        end else begin
            tx_ready_r <= 1'b0;
            if (state_r == ST_IDLE) begin
                div_r <= '0;
            end else if (strobe_s) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + DIV_W'(1);
            end

            case (state_r)
                ST_IDLE: begin
                    if (tx_valid) begin
                        state_r   <= ST_SYNC;
                        d_oe_r    <= 1'b1;
                        d_p_r     <= 1'b0;
                        d_n_r     <= 1'b1;
                        bit_idx_r <= 3'd0;
                        ones_r    <= 3'd0;
                    end
                end
                ST_SYNC, ST_DATA: begin
                    if (load_s) begin
                        state_r    <= ST_DATA;
                        shreg_r    <= tx_data;
                        bit_idx_r  <= 3'd0;
                        tx_ready_r <= 1'b1;
                    end
                    if (eop_s) begin
                        state_r   <= ST_EOP_SE0;
                        d_p_r     <= 1'b0;
                        d_n_r     <= 1'b0;
                        bit_idx_r <= 3'd0;
                    end
                    if (adv_s) begin
                        bit_idx_r <= next_idx_s;
                    end
                    if (emit_en_s) begin
                        if (!emit_val_s) begin
                            d_p_r  <= ~d_p_r;
                            d_n_r  <= ~d_n_r;
                            ones_r <= 3'd0;
                        end else begin
                            ones_r <= ones_r + 3'd1;
                        end
                    end
                end
                ST_EOP_SE0: begin
                    if (strobe_s) begin
                        if (bit_idx_r == 3'd1) begin
                            state_r   <= ST_EOP_J;
                            d_p_r     <= 1'b1;
                            d_n_r     <= 1'b0;
                            bit_idx_r <= 3'd0;
                        end else begin
                            bit_idx_r <= 3'd1;
                        end
                    end
                end
                ST_EOP_J: begin
                    if (strobe_s) begin
                        state_r <= ST_IDLE;
                        d_oe_r  <= 1'b0;
                        d_p_r   <= 1'b1;
                        d_n_r   <= 1'b0;
                        ones_r  <= 3'd0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    d_oe_r  <= 1'b0;
                    d_p_r   <= 1'b1;
                    d_n_r   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_r;
    assign d_p      = d_p_r;
    assign d_n      = d_n_r;
    assign d_oe     = d_oe_r;

endmodule

// File: tb/tb_usb_tx_phy.sv
// Scoreboard bench for usb_tx_phy: expected per-clock line state is queued from a bit-level
// model (or a literal symbol string) and compared against the DUT on every falling edge.
module tb_usb_tx_phy;

    localparam int CLK_DIV = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       d_p;
    logic       d_n;
    logic       d_oe;

    int checks;
    int failures;

    logic [3:0] exp_q[$];
    logic [7:0] pkt_q[$];
    logic       model_line;
    int         model_ones;

    usb_tx_phy #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .d_p      (d_p),
        .d_n      (d_n),
        .d_oe     (d_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue one bit period of {d_p,d_n,d_oe,tx_ready}; tx_ready only on its first clock.
    task automatic push_sym(input logic dp, input logic dn, input logic rdy);
        for (int c = 0; c < CLK_DIV; c++) begin
            exp_q.push_back({dp, dn, 1'b1, (c == 0) ? rdy : 1'b0});
        end
    endtask

    task automatic model_emit(input logic b, input logic rdy);
        if (!b) model_line = ~model_line;
        model_ones = b ? model_ones + 1 : 0;
        push_sym(model_line, ~model_line, rdy);
    endtask

    task automatic build_expected();
        exp_q.delete();
        model_line = 1'b1;
        model_ones = 0;
        for (int i = 0; i < 8; i++) model_emit(i == 7, 1'b0);
        foreach (pkt_q[k]) begin
            for (int i = 0; i < 8; i++) begin
                model_emit(pkt_q[k][i], i == 0);
                if (model_ones == 6) model_emit(1'b0, 1'b0);
            end
        end
        push_sym(1'b0, 1'b0, 1'b0);
        push_sym(1'b0, 1'b0, 1'b0);
        push_sym(1'b1, 1'b0, 1'b0);
        exp_q.push_back(4'b1000);
    endtask

    // Start a packet, act as the SIE on tx_ready, and compare every clock against exp_q.
    task automatic run_packet(input string name);
        int idx;
        int clk_n;
        logic [3:0] e;
        logic [3:0] obs;
        idx = 0;
        clk_n = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = (pkt_q.size() > 0) ? pkt_q[0] : 8'h00;
        @(posedge clk);
        #1;
        if (pkt_q.size() == 0) tx_valid = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            obs = {d_p, d_n, d_oe, tx_ready};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL %s clk=%0d {dp,dn,oe,rdy} got=%b want=%b", name, clk_n, obs, e);
            end
            if (tx_ready) begin
                idx++;
                if (idx < pkt_q.size()) tx_data = pkt_q[idx];
                else tx_valid = 1'b0;
            end
            clk_n++;
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({d_p, d_n, d_oe, tx_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_state got=%b want=1000", {d_p, d_n, d_oe, tx_ready});
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({d_p, d_n, d_oe, tx_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL idle_after_reset got=%b want=1000", {d_p, d_n, d_oe, tx_ready});
        end
    endtask

    // ACK handshake against a literal line pattern rather than the model.
    task automatic test_ack();
        string s;
        s = "KJKJKJKKJJKJJKKK";
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (s[i] == "K") push_sym(1'b0, 1'b1, i == 8);
            else push_sym(1'b1, 1'b0, i == 8);
        end
        push_sym(1'b0, 1'b0, 1'b0);
        push_sym(1'b0, 1'b0, 1'b0);
        push_sym(1'b1, 1'b0, 1'b0);
        exp_q.push_back(4'b1000);
        pkt_q = '{8'hD2};
        run_packet("ack");
    endtask

    task automatic test_stuffing();
        pkt_q = '{8'hFF};
        build_expected();
        checks++;
        if (exp_q.size() != (8 + 9 + 3) * CLK_DIV + 1) begin
            failures++;
            $display("FAIL stuff_len got=%0d want=%0d", exp_q.size(), (8 + 9 + 3) * CLK_DIV + 1);
        end
        run_packet("stuff_ff");
    endtask

    task automatic test_cross_byte();
        pkt_q = '{8'hFF, 8'hFF};
        build_expected();
        checks++;
        if (exp_q.size() != (8 + 18 + 3) * CLK_DIV + 1) begin
            failures++;
            $display("FAIL cross_len got=%0d want=%0d", exp_q.size(), (8 + 18 + 3) * CLK_DIV + 1);
        end
        run_packet("cross_ff_ff");
    endtask

    task automatic test_stuff_before_eop();
        pkt_q = '{8'h80, 8'hFC};
        build_expected();
        run_packet("stuff_eop");
    endtask

    task automatic test_empty();
        pkt_q.delete();
        build_expected();
        run_packet("empty");
    endtask

    task automatic test_back_to_back();
        pkt_q = '{8'h01, 8'hFF, 8'h7E, 8'h3F};
        build_expected();
        run_packet("multi");
    endtask

    task automatic test_reset_mid_data();
        int rdy_seen;
        int budget;
        rdy_seen = 0;
        budget   = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        while (rdy_seen < 2 && budget < 300) begin
            @(negedge clk);
            budget++;
            if (tx_ready) begin
                rdy_seen++;
                tx_data = 8'h00;
            end
        end
        checks++;
        if (rdy_seen != 2) begin
            failures++;
            $display("FAIL rst_mid_wait got=%0d pulses want=2", rdy_seen);
        end
        repeat (6) @(negedge clk);
        reset_n = 1'b0;
        tx_valid = 1'b0;
        #1;
        checks++;
        if ({d_p, d_n, d_oe, tx_ready} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid_async got=%b want=1000", {d_p, d_n, d_oe, tx_ready});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if ({d_p, d_n, d_oe, tx_ready} !== 4'b1000) begin
                failures++;
                $display("FAIL rst_mid_idle clk=%0d got=%b want=1000", i, {d_p, d_n, d_oe, tx_ready});
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ack();
        test_stuffing();
        test_cross_byte();
        test_stuff_before_eop();
        test_empty();
        test_back_to_back();
        test_reset_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
